// File: rtl/thread_scoreboard.sv
// thread_scoreboard
// Per-thread busy tracking for 4 warps x 8 threads. Each thread has a
// countdown (fixed-latency ops) and a sticky flag (variable-latency ops that
// are released by writeback). An issue is accepted only when none of its
// threads are busy.
// Optional feature: define THREAD_SCOREBOARD_PERF_EN to add a saturating
// 16-bit reject_count output.
// NUM_THREADS must be 32 (4 warps of 8 threads).
module thread_scoreboard #(
  parameter int NUM_THREADS = 32,
  parameter int LAT_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic [1:0]             issue_warp,
  input  logic [7:0]             issue_mask,
  input  logic [LAT_W-1:0]       issue_lat,
  output logic                   issue_accept,
  input  logic                   wb_valid,
  input  logic [1:0]             wb_warp,
  input  logic [7:0]             wb_mask,
  output logic [NUM_THREADS-1:0] busy_threads,
  output logic                   sb_idle
`ifdef THREAD_SCOREBOARD_PERF_EN
  ,
  output logic [15:0]            reject_count
`endif
);

  logic [LAT_W-1:0]       r_cnt [NUM_THREADS];
  logic [NUM_THREADS-1:0] r_sticky;

  logic [NUM_THREADS-1:0] w_busy;
  logic [NUM_THREADS-1:0] w_issue_full;
  logic [NUM_THREADS-1:0] w_issue_vec;
  logic [NUM_THREADS-1:0] w_wb_vec;
  logic                   w_conflict;

  // Spread an 8-bit warp mask into the full thread vector; warp 0 sits in
  // the most significant byte.
  function automatic logic [NUM_THREADS-1:0] place(input logic [1:0] warp,
                                                   input logic [7:0] mask);
    logic [NUM_THREADS-1:0] v;
    int                     base;
    v    = '0;
    base = NUM_THREADS - 8 - 8 * int'(warp);
    v[base +: 8] = mask;
    return v;
  endfunction

  // Busy view of the registered per-thread state.
  always_comb begin
    w_busy = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      w_busy[i] = (r_cnt[i] != '0) || r_sticky[i];
    end
  end

  // Accept decision against registered state only; writebacks and expiries
  // in the same cycle do not make room for this issue.
  always_comb begin
    w_issue_full = place(issue_warp, issue_mask);
    w_conflict   = |(w_issue_full & w_busy);
    issue_accept = rst_n && issue_valid && !w_conflict;
    w_issue_vec  = issue_accept ? w_issue_full : '0;
    w_wb_vec     = wb_valid ? place(wb_warp, wb_mask) : '0;
  end

  assign busy_threads = w_busy;
  assign sb_idle      = ~|w_busy;

  // Per-thread update: accepted issue wins over writeback, writeback clears,
  // otherwise a running countdown steps toward zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        r_cnt[i] <= '0;
      end
      r_sticky <= '0;
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (w_issue_vec[i]) begin
          if (issue_lat != '0) begin
            r_cnt[i]    <= issue_lat;
            r_sticky[i] <= 1'b0;
          end else begin
            r_cnt[i]    <= '0;
            r_sticky[i] <= 1'b1;
          end
        end else if (w_wb_vec[i]) begin
          r_cnt[i]    <= '0;
          r_sticky[i] <= 1'b0;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - LAT_W'(1);
        end
      end
    end
  end

`ifdef THREAD_SCOREBOARD_PERF_EN
  logic [15:0] r_reject_cnt;
  logic        w_reject;

  assign w_reject     = issue_valid && !issue_accept;
  assign reject_count = r_reject_cnt;

  // Count rejected issue cycles, holding at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reject_cnt <= '0;
    end else if (w_reject && (r_reject_cnt != 16'hFFFF)) begin
      r_reject_cnt <= r_reject_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_thread_scoreboard.sv
// Bench for thread_scoreboard: directed scenarios plus randomized traffic
// checked against a release-time reference model.
module tb_thread_scoreboard;
  localparam int NT    = 32;
  localparam int LAT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             issue_valid;
  logic [1:0]       issue_warp;
  logic [7:0]       issue_mask;
  logic [LAT_W-1:0] issue_lat;
  logic             issue_accept;
  logic             wb_valid;
  logic [1:0]       wb_warp;
  logic [7:0]       wb_mask;
  logic [NT-1:0]    busy_threads;
  logic             sb_idle;
`ifdef THREAD_SCOREBOARD_PERF_EN
  logic [15:0]      reject_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  thread_scoreboard #(.NUM_THREADS(NT), .LAT_W(LAT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_warp   (issue_warp),
    .issue_mask   (issue_mask),
    .issue_lat    (issue_lat),
    .issue_accept (issue_accept),
    .wb_valid     (wb_valid),
    .wb_warp      (wb_warp),
    .wb_mask      (wb_mask),
    .busy_threads (busy_threads),
    .sb_idle      (sb_idle)
`ifdef THREAD_SCOREBOARD_PERF_EN
    ,
    .reject_count (reject_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    issue_valid = 1'b0;
    issue_warp  = 2'd0;
    issue_mask  = 8'h00;
    issue_lat   = '0;
    wb_valid    = 1'b0;
    wb_warp     = 2'd0;
    wb_mask     = 8'h00;
  endtask

  task automatic set_issue(input logic [1:0] w, input logic [7:0] m,
                           input logic [LAT_W-1:0] l);
    issue_valid = 1'b1;
    issue_warp  = w;
    issue_mask  = m;
    issue_lat   = l;
  endtask

  task automatic set_wb(input logic [1:0] w, input logic [7:0] m);
    wb_valid = 1'b1;
    wb_warp  = w;
    wb_mask  = m;
  endtask

  task automatic reset_dut();
    idle_in();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_in();
    set_issue(2'd0, 8'hFF, 4'd3);
    #2;
    checks++;
    if (busy_threads !== 32'h0) begin
      errors++; $display("FAIL reset_busy got %h want %h", busy_threads, 32'h0);
    end
    checks++;
    if (sb_idle !== 1'b1) begin
      errors++; $display("FAIL reset_idle got %b want 1", sb_idle);
    end
    checks++;
    if (issue_accept !== 1'b0) begin
      errors++; $display("FAIL reset_accept got %b want 0", issue_accept);
    end
`ifdef THREAD_SCOREBOARD_PERF_EN
    checks++;
    if (reject_count !== 16'h0) begin
      errors++; $display("FAIL reset_rejcnt got %h want 0", reject_count);
    end
`endif
    idle_in();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fixed_latency();
    set_issue(2'd0, 8'hFF, 4'd3);
    #1;
    checks++;
    if (issue_accept !== 1'b1) begin
      errors++; $display("FAIL fixed_accept got %b want 1", issue_accept);
    end
    tick();
    idle_in();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (busy_threads !== 32'hFF00_0000 || sb_idle !== 1'b0) begin
        errors++;
        $display("FAIL fixed_busy cyc %0d got %h idle %b want ff000000 idle 0",
                 c, busy_threads, sb_idle);
      end
      tick();
    end
    checks++;
    if (busy_threads !== 32'h0 || sb_idle !== 1'b1) begin
      errors++;
      $display("FAIL fixed_clear got %h idle %b want 0 idle 1", busy_threads, sb_idle);
    end
  endtask

  task automatic test_variable_latency();
    set_issue(2'd2, 8'h0F, 4'd0);
    #1;
    checks++;
    if (issue_accept !== 1'b1) begin
      errors++; $display("FAIL var_accept got %b want 1", issue_accept);
    end
    tick();
    set_issue(2'd2, 8'h01, 4'd5);
    #1;
    checks++;
    if (issue_accept !== 1'b0) begin
      errors++; $display("FAIL var_conflict got %b want 0", issue_accept);
    end
    tick();
    checks++;
    if (busy_threads !== 32'h0000_0F00) begin
      errors++; $display("FAIL var_sticky got %h want 00000f00", busy_threads);
    end
    // zero mask is always accepted and changes nothing
    set_issue(2'd2, 8'h00, 4'd3);
    #1;
    checks++;
    if (issue_accept !== 1'b1) begin
      errors++; $display("FAIL zero_mask_accept got %b want 1", issue_accept);
    end
    tick();
    idle_in();
    set_wb(2'd2, 8'h0F);
    tick();
    idle_in();
    checks++;
    if (busy_threads !== 32'h0) begin
      errors++; $display("FAIL var_wb_clear got %h want 0", busy_threads);
    end
  endtask

  task automatic test_same_cycle();
    set_issue(2'd1, 8'h01, 4'd0);
    tick();
    set_issue(2'd1, 8'h01, 4'd2);
    set_wb(2'd1, 8'h01);
    #1;
    checks++;
    if (issue_accept !== 1'b0) begin
      errors++; $display("FAIL same_busy_accept got %b want 0", issue_accept);
    end
    tick();
    idle_in();
    checks++;
    if (busy_threads !== 32'h0) begin
      errors++; $display("FAIL same_wb_clear got %h want 0", busy_threads);
    end
    // idle thread: issue and writeback together, issue wins
    set_issue(2'd1, 8'h01, 4'd2);
    set_wb(2'd1, 8'h01);
    #1;
    checks++;
    if (issue_accept !== 1'b1) begin
      errors++; $display("FAIL same_idle_accept got %b want 1", issue_accept);
    end
    tick();
    idle_in();
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (busy_threads !== 32'h0001_0000) begin
        errors++; $display("FAIL same_issue_wins cyc %0d got %h want 00010000", c, busy_threads);
      end
      tick();
    end
    checks++;
    if (busy_threads !== 32'h0) begin
      errors++; $display("FAIL same_expire got %h want 0", busy_threads);
    end
  endtask

  task automatic test_back_to_back();
    set_issue(2'd3, 8'h01, 4'd1);
    tick();
    #1;
    checks++;
    if (issue_accept !== 1'b0) begin
      errors++; $display("FAIL b2b_reject got %b want 0", issue_accept);
    end
    tick();
    #1;
    checks++;
    if (issue_accept !== 1'b1) begin
      errors++; $display("FAIL b2b_accept got %b want 1", issue_accept);
    end
    tick();
    idle_in();
    checks++;
    if (busy_threads !== 32'h0000_0001) begin
      errors++; $display("FAIL b2b_busy got %h want 00000001", busy_threads);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    set_issue(2'd1, 8'hF0, 4'd0);
    tick();
    set_issue(2'd0, 8'h3C, 4'd9);
    tick();
    idle_in();
    checks++;
    if (busy_threads !== 32'h3CF0_0000) begin
      errors++; $display("FAIL midrst_pre got %h want 3cf00000", busy_threads);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_threads !== 32'h0 || sb_idle !== 1'b1) begin
      errors++; $display("FAIL midrst_now got %h idle %b want 0 idle 1", busy_threads, sb_idle);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    set_wb(2'd1, 8'hF0);
    tick();
    idle_in();
    checks++;
    if (busy_threads !== 32'h0) begin
      errors++; $display("FAIL midrst_wb got %h want 0", busy_threads);
    end
  endtask

  // Reference model: each thread records the edge count at which a fixed
  // latency op stops being busy, plus a sticky flag for variable latency.
  int unsigned rel [NT];
  bit          stk [NT];
  int unsigned cyc;

  function automatic logic [NT-1:0] model_busy();
    logic [NT-1:0] b;
    for (int i = 0; i < NT; i++) b[i] = stk[i] || (cyc < rel[i]);
    return b;
  endfunction

  task automatic test_random();
    logic [NT-1:0]    exp_busy;
    logic             exp_acc;
    logic             iv, wv;
    logic [1:0]       iw, ww;
    logic [7:0]       im, wm;
    logic [LAT_W-1:0] il;
    int               ib, wbase;
    reset_dut();
    for (int i = 0; i < NT; i++) begin
      rel[i] = 0;
      stk[i] = 1'b0;
    end
    cyc = 0;
    for (int n = 0; n < 400; n++) begin
      iv = ($urandom_range(0, 9) < 7);
      iw = 2'($urandom_range(0, 3));
      im = 8'($urandom & $urandom);
      il = ($urandom_range(0, 3) == 0) ? '0 : LAT_W'($urandom_range(1, 6));
      wv = ($urandom_range(0, 1) == 1);
      ww = 2'($urandom_range(0, 3));
      wm = 8'($urandom);
      issue_valid = iv; issue_warp = iw; issue_mask = im; issue_lat = il;
      wb_valid = wv; wb_warp = ww; wb_mask = wm;
      #1;
      exp_busy = model_busy();
      ib       = 24 - 8 * int'(iw);
      wbase    = 24 - 8 * int'(ww);
      exp_acc  = iv && ((exp_busy[ib +: 8] & im) == 8'h00);
      checks++;
      if (issue_accept !== exp_acc) begin
        errors++; $display("FAIL rand_accept n %0d got %b want %b", n, issue_accept, exp_acc);
      end
      tick();
      cyc++;
      for (int k = 0; k < 8; k++) begin
        if (wv && wm[k]) begin
          rel[wbase + k] = 0;
          stk[wbase + k] = 1'b0;
        end
      end
      for (int k = 0; k < 8; k++) begin
        if (exp_acc && im[k]) begin
          if (il == '0) begin
            stk[ib + k] = 1'b1;
            rel[ib + k] = 0;
          end else begin
            stk[ib + k] = 1'b0;
            rel[ib + k] = cyc + int'(il);
          end
        end
      end
      exp_busy = model_busy();
      checks++;
      if (busy_threads !== exp_busy || sb_idle !== (exp_busy == '0)) begin
        errors++;
        $display("FAIL rand_busy n %0d got %h idle %b want %h", n, busy_threads, sb_idle, exp_busy);
      end
    end
    idle_in();
  endtask

`ifdef THREAD_SCOREBOARD_PERF_EN
  task automatic test_perf();
    int n;
    reset_dut();
    checks++;
    if (reject_count !== 16'd0) begin
      errors++; $display("FAIL perf_zero got %h want 0", reject_count);
    end
    set_issue(2'd0, 8'hFF, 4'd0);
    tick();
    set_issue(2'd0, 8'h01, 4'd3);
    for (int i = 0; i < 5; i++) tick();
    set_issue(2'd1, 8'h01, 4'd0);
    tick();
    idle_in();
    tick();
    checks++;
    if (reject_count !== 16'd5) begin
      errors++; $display("FAIL perf_five got %h want 5", reject_count);
    end
    set_issue(2'd0, 8'h80, 4'd2);
    n = 0;
    while (reject_count != 16'hFFFE && n < 70000) begin
      tick();
      n++;
    end
    checks++;
    if (reject_count !== 16'hFFFE) begin
      errors++; $display("FAIL perf_fffe got %h want fffe", reject_count);
    end
    for (int i = 0; i < 3; i++) tick();
    idle_in();
    checks++;
    if (reject_count !== 16'hFFFF) begin
      errors++; $display("FAIL perf_sat got %h want ffff", reject_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fixed_latency();
    test_variable_latency();
    test_same_cycle();
    test_back_to_back();
    test_reset_midrun();
    test_random();
`ifdef THREAD_SCOREBOARD_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
